// File: rtl/tech_regfile_mp.sv
// Multi-read-port register file with byte-masked write port and a clear engine.
// Optional TECH_REGFILE_MP_BYPASS_EN: write-first forwarding on same-address reads.
module tech_regfile_mp #(
  parameter int                   BIT_WIDTH  = 32,
  parameter int                   WORD_DEPTH = 32,
  parameter int                   RD_PORTS   = 2,
  parameter logic [BIT_WIDTH-1:0] INIT_VAL   = '0,
  localparam int                  AW         = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          clr_i,
  output logic                          busy_o,
  input  logic                          wen_i,
  input  logic [AW-1:0]                 waddr_i,
  input  logic [BIT_WIDTH/8-1:0]        wbm_i,
  input  logic [BIT_WIDTH-1:0]          wdat_i,
  input  logic [RD_PORTS-1:0]           ren_i,
  input  logic [RD_PORTS*AW-1:0]        raddr_i,
  output logic [RD_PORTS*BIT_WIDTH-1:0] rdat_o
);

  localparam int NB = BIT_WIDTH / 8;
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(WORD_DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(WORD_DEPTH - 1);

  logic                 state;
  logic [AW-1:0]        cnt;
  logic                 ready;
  logic                 waddr_ok;
  logic                 wr_ok;
  logic [BIT_WIDTH-1:0] wr_old;
  logic [BIT_WIDTH-1:0] wr_word;
  logic [BIT_WIDTH-1:0] mem [WORD_DEPTH];

  assign ready    = (state == ST_READY);
  assign busy_o   = ~ready;
  assign waddr_ok = ({1'b0, waddr_i} < DEPTH_W);
  assign wr_ok    = ready && wen_i && waddr_ok;
  assign wr_old   = waddr_ok ? mem[waddr_i] : '0;

  always_comb begin
    wr_word = wr_old;
    for (int b = 0; b < NB; b++) begin
      if (wbm_i[b]) wr_word[8*b +: 8] = wdat_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == LAST) begin
            state <= ST_READY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (clr_i) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Storage has no reset; the clear engine owns it while busy.
  always_ff @(posedge clk_i) begin
    if (!ready) begin
      mem[cnt] <= INIT_VAL;
    end else if (wr_ok) begin
      mem[waddr_i] <= wr_word;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [AW-1:0]        ra;
    logic                 ra_ok;
    logic [BIT_WIDTH-1:0] rd_next;
    logic [BIT_WIDTH-1:0] rd_q;

    assign ra    = raddr_i[p*AW +: AW];
    assign ra_ok = ({1'b0, ra} < DEPTH_W);

    always_comb begin
      rd_next = ra_ok ? mem[ra] : '0;
`ifdef TECH_REGFILE_MP_BYPASS_EN
      if (wr_ok && (waddr_i == ra)) rd_next = wr_word;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        rd_q <= '0;
      end else if (ready && ren_i[p]) begin
        rd_q <= rd_next;
      end
    end

    assign rdat_o[p*BIT_WIDTH +: BIT_WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_tech_regfile_mp.sv
// Scoreboard bench for tech_regfile_mp (WORD_DEPTH=24, two read ports, INIT_VAL=A5A5A5A5).
module tb_tech_regfile_mp;

  localparam int          D    = 24;
  localparam int          AW   = 5;
  localparam logic [31:0] INIT = 32'hA5A5_A5A5;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        busy_o;
  logic        wen_i = 1'b0;
  logic [4:0]  waddr_i = '0;
  logic [3:0]  wbm_i = '0;
  logic [31:0] wdat_i = '0;
  logic [1:0]  ren_i = '0;
  logic [9:0]  raddr_i = '0;
  logic [63:0] rdat_o;

  tech_regfile_mp #(
    .BIT_WIDTH (32),
    .WORD_DEPTH(D),
    .RD_PORTS  (2),
    .INIT_VAL  (INIT)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (clr_i),
    .busy_o (busy_o),
    .wen_i  (wen_i),
    .waddr_i(waddr_i),
    .wbm_i  (wbm_i),
    .wdat_i (wdat_i),
    .ren_i  (ren_i),
    .raddr_i(raddr_i),
    .rdat_o (rdat_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        busy;
    logic [31:0] rd [2];
  } exp_t;

  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        started = 1'b0;

  // Reference model: word contents, clear cycles left, last read results.
  logic [31:0] words [D];
  int          clr_left = D;
  logic [31:0] rd_m [2] = '{32'h0, 32'h0};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] bm);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (bm[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic clr, input logic wen,
                            input logic [4:0] wa, input logic [3:0] bm, input logic [31:0] wd,
                            input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1);
    exp_t e;
    logic [4:0] ra [2];
    ra[0] = ra0;
    ra[1] = ra1;
    if (!rst) begin
      clr_left = D;
      rd_m[0] = '0;
      rd_m[1] = '0;
    end else if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) for (int i = 0; i < D; i++) words[i] = INIT;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (ren[p]) begin
          if (int'(ra[p]) < D) begin
            rd_m[p] = words[ra[p]];
`ifdef TECH_REGFILE_MP_BYPASS_EN
            if (wen && wa == ra[p]) rd_m[p] = merge(words[ra[p]], wd, bm);
`endif
          end else begin
            rd_m[p] = '0;
          end
        end
      end
      if (wen && int'(wa) < D) words[wa] = merge(words[wa], wd, bm);
      if (clr) clr_left = D;
    end
    e.busy  = (clr_left > 0);
    e.rd[0] = rd_m[0];
    e.rd[1] = rd_m[1];
    sb.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic clr, input logic wen,
                     input logic [4:0] wa, input logic [3:0] bm, input logic [31:0] wd,
                     input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1);
    logic was_rst;
    @(negedge clk_i);
    was_rst = rst_n_i;
    rst_n_i = rst;
    clr_i   = clr;
    wen_i   = wen;
    waddr_i = wa;
    wbm_i   = bm;
    wdat_i  = wd;
    ren_i   = ren;
    raddr_i = {ra1, ra0};
    started = 1'b1;
    if (was_rst && !rst) begin
      #1;
      check("async_rst_rd0", rdat_o[31:0], 32'h0);
      check("async_rst_rd1", rdat_o[63:32], 32'h0);
      check("async_rst_busy", {31'h0, busy_o}, 32'h1);
    end
    model_step(rst, clr, wen, wa, bm, wd, ren, ra0, ra1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 2'b00, '0, '0);
  endtask

  task automatic rnd(input int n, input bit allow_clr);
    for (int i = 0; i < n; i++)
      cyc(1'b1, allow_clr && ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), 4'($urandom), $urandom, 2'($urandom),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  // Monitor: one scoreboard entry per clock edge, compared just after it.
  initial begin
    exp_t e;
    wait (started);
    forever begin
      @(posedge clk_i);
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_empty: no expected entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("busy", {31'h0, busy_o}, {31'h0, e.busy});
        check("rdat0", rdat_o[31:0], e.rd[0]);
        check("rdat1", rdat_o[63:32], e.rd[1]);
      end
    end
  end

  initial begin
    #1;
    check("reset_busy", {31'h0, busy_o}, 32'h1);
    check("reset_rdat", rdat_o[31:0] | rdat_o[63:32], 32'h0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, '0, '0);
    // Release, with random traffic during the clear that must all be ignored.
    rnd(D + 2, 1'b0);
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 2'b11, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 2'b11, 5'd17, 5'd17);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 2'b11, 5'd23, 5'd23);
    // Byte-masked write then read.
    cyc(1'b1, 1'b0, 1'b1, 5'd5, 4'b0101, 32'h1122_3344, 2'b00, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 2'b01, 5'd5, '0);
    // Two ports, different addresses, then hold.
    cyc(1'b1, 1'b0, 1'b1, 5'd3, 4'hF, 32'hAAAA_0003, 2'b00, '0, '0);
    cyc(1'b1, 1'b0, 1'b1, 5'd9, 4'hF, 32'hBBBB_0009, 2'b00, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 2'b11, 5'd3, 5'd9);
    cyc(1'b1, 1'b0, 1'b1, 5'd3, 4'hF, 32'h0, 2'b00, 5'd0, 5'd0);
    idle(1);
    // Same-cycle write and read to one address.
    cyc(1'b1, 1'b0, 1'b1, 5'd7, 4'hF, 32'hDEAD_BEEF, 2'b11, 5'd7, 5'd7);
    cyc(1'b1, 1'b0, 1'b1, 5'd7, 4'b0011, 32'h0000_1234, 2'b01, 5'd7, 5'd8);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 2'b10, '0, 5'd7);
    // Out-of-range write and read.
    cyc(1'b1, 1'b0, 1'b1, 5'd30, 4'hF, 32'h1357_9BDF, 2'b00, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 2'b11, 5'd30, 5'd0);
    // Write coincident with clear start, write during clear, reset mid-clear.
    cyc(1'b1, 1'b1, 1'b1, 5'd2, 4'hF, 32'h2222_2222, 2'b00, '0, '0);
    cyc(1'b1, 1'b0, 1'b1, 5'd2, 4'hF, 32'h3333_3333, 2'b11, 5'd2, 5'd2);
    idle(8);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, '0, '0);
    rnd(D + 1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 2'b11, 5'd2, 5'd5);
    // Random traffic with occasional clear pulses.
    rnd(600, 1'b1);
    idle(2);
    @(posedge clk_i);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
